// File: rtl/block_raster_writer.sv
// block_raster_writer
//
// Takes complete 8x8 pixel blocks from the decode pipeline, buffers each one,
// and writes it pixel by pixel into the shared image RAM in raster order. The
// block also arbitrates the image RAM between its own writes and the filter
// controller's single-cycle fetches. It reports frame progress in completed
// block rows so that the filter can trail the decoder.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   block_valid/block_data   incoming block; pixel k=px+8*py at [k*PW +: PW]
//   block_ready              writer is idle and can accept a block
//   filter_RAM_request       filter wants a RAM read this cycle
//   is_image_RAM_available   filter read granted this cycle
//   image_RAM_CE/WE          write strobe (WE always equals CE)
//   image_RAM_address/data   write address and pixel
//   completed_block_rows     fully written block rows in the current frame
//   block_row_done           one-cycle pulse when a block row completes
//   frame_done               one-cycle pulse when the frame completes
module block_raster_writer #(
    parameter int IMAGE_WIDTH             = 320,
    parameter int IMAGE_HEIGHT            = 240,
    parameter int BLOCK_SIZE              = 64,
    parameter int PIXEL_WIDTH             = 8,
    parameter int IMAGE_RAM_ADDRESS_WIDTH = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
    parameter int ROW_COUNT_WIDTH         = $clog2(IMAGE_HEIGHT/8+1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               block_valid,
    input  logic [BLOCK_SIZE*PIXEL_WIDTH-1:0]  block_data,
    output logic                               block_ready,
    input  logic                               filter_RAM_request,
    output logic                               is_image_RAM_available,
    output logic                               image_RAM_CE,
    output logic                               image_RAM_WE,
    output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] image_RAM_address,
    output logic [PIXEL_WIDTH-1:0]             image_RAM_data,
    output logic [ROW_COUNT_WIDTH-1:0]         completed_block_rows,
    output logic                               block_row_done,
    output logic                               frame_done
);

    localparam int COLS = IMAGE_WIDTH / 8;
    localparam int ROWS = IMAGE_HEIGHT / 8;
    localparam int BXW  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int BYW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW   = $clog2(BLOCK_SIZE);
    localparam int AW   = IMAGE_RAM_ADDRESS_WIDTH;

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t                     state_q;
    logic [PW-1:0]              p_q;
    logic [BXW-1:0]             bx_q;
    logic [BYW-1:0]             by_q;
    logic [ROW_COUNT_WIDTH-1:0] rows_q;
    logic                       granted_q;
    logic                       wrote_q;
    logic                       row_done_q;
    logic                       frame_done_q;
    logic [PIXEL_WIDTH-1:0]     buf_q [BLOCK_SIZE];

    logic in_write;
    logic wr;
    logic load_hold;

    // The cycle after a grant is the filter's LOAD cycle: no write then, and
    // no new grant either, so a held request settles into write/grant/hold.
    // Right after a write, a pending request takes priority over the next
    // write, so the filter waits at most one cycle.
    assign in_write  = !rst && (state_q == S_WRITE);
    assign load_hold = in_write && granted_q;
    assign wr        = in_write && !granted_q && !(filter_RAM_request && wrote_q);

    assign is_image_RAM_available = filter_RAM_request && !(wr || load_hold);
    assign block_ready            = !rst && (state_q == S_IDLE);
    assign image_RAM_CE           = wr;
    assign image_RAM_WE           = wr;

    // {by,py} = 8*by+py is the line, {bx,px} = 8*bx+px is the column.
    assign image_RAM_address = wr ? (AW'({by_q, p_q[5:3]}) * AW'(IMAGE_WIDTH)
                                     + AW'({bx_q, p_q[2:0]})) : '0;
    assign image_RAM_data    = wr ? buf_q[p_q] : '0;

    assign completed_block_rows = rows_q;
    assign block_row_done       = row_done_q && !rst;
    assign frame_done           = frame_done_q && !rst;

    // Block buffer: captured whole on accept, never sampled otherwise.
    always_ff @(posedge clk) begin
        if (block_valid && block_ready) begin
            for (int k = 0; k < BLOCK_SIZE; k++)
                buf_q[k] <= block_data[k*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            p_q          <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            rows_q       <= '0;
            granted_q    <= 1'b0;
            wrote_q      <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            granted_q    <= is_image_RAM_available;
            wrote_q      <= wr;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (block_valid) begin
                        state_q <= S_WRITE;
                        p_q     <= '0;
                    end
                end
                S_WRITE: begin
                    if (wr) begin
                        p_q <= p_q + PW'(1);
                        if (p_q == PW'(BLOCK_SIZE-1)) begin
                            state_q <= S_IDLE;
                            if (bx_q == BXW'(COLS-1)) begin
                                bx_q       <= '0;
                                row_done_q <= 1'b1;
                                if (by_q == BYW'(ROWS-1)) begin
                                    by_q         <= '0;
                                    rows_q       <= '0;
                                    frame_done_q <= 1'b1;
                                end else begin
                                    by_q   <= by_q + BYW'(1);
                                    rows_q <= rows_q + ROW_COUNT_WIDTH'(1);
                                end
                            end else begin
                                bx_q <= bx_q + BXW'(1);
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_raster_writer.sv
// Directed bench for block_raster_writer: reset state, single blocks with and
// without filter traffic, a full frame with row/frame pulses, and mid-block
// reset. A negedge monitor predicts every RAM write address and pixel.
module tb_block_raster_writer;

    localparam int IW = 320;
    localparam int IH = 240;
    localparam int BS = 64;
    localparam int PXW = 8;
    localparam int AW = 17;
    localparam int RW = 5;
    localparam int NBLK = (IW/8)*(IH/8);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              block_valid = 1'b0;
    logic [BS*PXW-1:0] block_data = '0;
    logic              block_ready;
    logic              filter_RAM_request = 1'b0;
    logic              is_image_RAM_available;
    logic              image_RAM_CE;
    logic              image_RAM_WE;
    logic [AW-1:0]     image_RAM_address;
    logic [PXW-1:0]    image_RAM_data;
    logic [RW-1:0]     completed_block_rows;
    logic              block_row_done;
    logic              frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k_exp = 0;
    int blk_exp = 0;
    int cur_seed = 0;
    logic prev_avail = 1'b0;

    block_raster_writer #(
        .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .BLOCK_SIZE(BS), .PIXEL_WIDTH(PXW),
        .IMAGE_RAM_ADDRESS_WIDTH(AW), .ROW_COUNT_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .block_valid(block_valid), .block_data(block_data), .block_ready(block_ready),
        .filter_RAM_request(filter_RAM_request),
        .is_image_RAM_available(is_image_RAM_available),
        .image_RAM_CE(image_RAM_CE), .image_RAM_WE(image_RAM_WE),
        .image_RAM_address(image_RAM_address), .image_RAM_data(image_RAM_data),
        .completed_block_rows(completed_block_rows),
        .block_row_done(block_row_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int seed, input int k);
        return 8'((k + 7*seed) & 255);
    endfunction

    function automatic int addr_of(input int blk, input int k);
        int bx, by;
        bx = blk % (IW/8);
        by = blk / (IW/8);
        return (8*by + k/8)*IW + 8*bx + k%8;
    endfunction

    // Write monitor: every write must be the next pixel of the expected block.
    always @(negedge clk) begin
        if (!rst) begin
            chk("we_eq_ce", image_RAM_WE, image_RAM_CE);
            if (prev_avail) chk("no_wr_after_grant", image_RAM_CE, 0);
            if (image_RAM_CE) begin
                chk("grant_excl", is_image_RAM_available, 0);
                chk("addr", image_RAM_address, addr_of(blk_exp, k_exp));
                chk("data", image_RAM_data, pix(cur_seed, k_exp));
                if (k_exp == BS-1) begin
                    k_exp = 0;
                    blk_exp = (blk_exp + 1) % NBLK;
                end else begin
                    k_exp++;
                end
            end
        end
        prev_avail = is_image_RAM_available;
    end

    // Offer one block, optionally inject a single-cycle request mid-burst,
    // then check ready latency and the row/frame bookkeeping.
    task automatic run_block(input int seed, input int fidx, input int exp_n, input bit mid_req);
        int t0, guard;
        cur_seed = seed;
        for (int k = 0; k < BS; k++) block_data[k*PXW +: PXW] = pix(seed, k);
        block_valid = 1'b1;
        @(posedge clk); #1;
        block_valid = 1'b0;
        t0 = cyc;
        for (int k = 0; k < BS; k++) block_data[k*PXW +: PXW] = 8'($urandom);
        if (mid_req) begin
            repeat (5) @(posedge clk);
            #1 filter_RAM_request = 1'b1;
            @(negedge clk);
            chk("mreq_grant", is_image_RAM_available, 1);
            chk("mreq_ce", image_RAM_CE, 0);
            @(posedge clk); #1 filter_RAM_request = 1'b0;
            @(negedge clk);
            chk("mreq_hold_ce", image_RAM_CE, 0);
            chk("mreq_hold_av", is_image_RAM_available, 0);
        end
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!block_ready && guard < 400);
        chk("ready_lat", cyc - t0 + 1, exp_n);
        chk("row_pulse", block_row_done, (fidx % (IW/8)) == (IW/8 - 1));
        chk("frame_pulse", frame_done, fidx == NBLK-1);
        chk("rows", completed_block_rows, ((fidx + 1) % NBLK) / (IW/8));
        @(posedge clk);
        @(negedge clk);
        chk("row_pulse_end", block_row_done, 0);
        chk("frame_pulse_end", frame_done, 0);
    endtask

    initial begin
        int seed;
        // Reset state with a filter request pending.
        filter_RAM_request = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", block_ready, 0);
        chk("rst_ce", image_RAM_CE, 0);
        chk("rst_we", image_RAM_WE, 0);
        chk("rst_addr", image_RAM_address, 0);
        chk("rst_data", image_RAM_data, 0);
        chk("rst_avail", is_image_RAM_available, 1);
        chk("rst_rows", completed_block_rows, 0);
        chk("rst_rowp", block_row_done, 0);
        chk("rst_frp", frame_done, 0);
        @(posedge clk); #1 rst = 1'b0;
        // Idle requests are granted every cycle.
        @(negedge clk);
        chk("idle_avail0", is_image_RAM_available, 1);
        chk("idle_ready", block_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_avail1", is_image_RAM_available, 1);
        @(posedge clk); #1 filter_RAM_request = 1'b0;
        @(negedge clk);

        // Frame 1: pixel k = k, then mid-burst request, then held request.
        run_block(0, 0, 65, 1'b0);
        run_block(1, 1, 67, 1'b1);
        @(posedge clk); #1 filter_RAM_request = 1'b1;
        @(negedge clk);
        chk("pre_held_avail", is_image_RAM_available, 1);
        run_block(2, 2, 192, 1'b0);
        @(posedge clk); #1 filter_RAM_request = 1'b0;
        @(negedge clk);
        seed = 3;
        for (int b = 3; b < NBLK; b++) begin
            run_block(seed, b, 65, 1'b0);
            seed++;
        end

        // Frame 2: first row plus block 40 (starts at line 8).
        for (int b = 0; b <= IW/8; b++) begin
            run_block(seed, b, 65, 1'b0);
            seed++;
        end

        // Reset in the middle of the next block, at p=30.
        cur_seed = seed;
        for (int k = 0; k < BS; k++) block_data[k*PXW +: PXW] = pix(seed, k);
        block_valid = 1'b1;
        @(posedge clk); #1 block_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        k_exp = 0;
        blk_exp = 0;
        @(negedge clk);
        chk("mrst_ce", image_RAM_CE, 0);
        chk("mrst_ready", block_ready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_rows", completed_block_rows, 0);
        chk("mrst_ready_after", block_ready, 1);
        for (int i = 0; i < 3; i++) begin
            chk("mrst_no_ce", image_RAM_CE, 0);
            @(negedge clk);
        end
        seed++;
        run_block(seed, 0, 65, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
